// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter: FSM states, requester ids,
// and default geometry of the 128x8 single-port RAM it fronts.
package sp_ram_arb_pkg;

  localparam int DEF_MEM_DEPTH  = 128;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from the request pair;
// the last-grant pointer only moves when the caller accepts the grant.
module rr_arb2
  import sp_ram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  req_id_t r_last;

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    o_grant = 2'b00;
    if (i_req == 2'b11) begin
      // Contention goes to whichever requester was not served last.
      o_grant = (r_last == REQ_B) ? 2'b01 : 2'b10;
    end else begin
      o_grant = i_req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_last <= REQ_B;
    end else if (i_accept && (o_grant != 2'b00)) begin
      r_last <= o_grant[1] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Sequencer in front of a single-port RAM: accepts one command from A or B,
// drives the RAM port for one cycle, then strobes the response to the winner.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic                  a_wr_en_i,
  input  logic                  a_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wr_data_i,
  output logic                  a_resp_o,
  output logic [DATA_WIDTH-1:0] a_rd_data_o,

  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic                  b_wr_en_i,
  input  logic                  b_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wr_data_i,
  output logic                  b_resp_o,
  output logic [DATA_WIDTH-1:0] b_rd_data_o,

  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic                  mem_wr_en_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            w_req;
  logic [1:0]            w_grant;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_resp_data;

  logic                  r_wr_en;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  req_id_t               r_owner;

  assign w_req = {b_valid_i, a_valid_i};

  // Gating with rst_i keeps every strobe low while reset is being applied.
  assign w_accept = rst_i && (r_state == IDLE) && (w_req != 2'b00);

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign mem_addr_o    = r_addr;
  assign mem_wr_data_o = r_wr_data;
  assign w_resp_data   = (rst_i && r_rd_en) ? mem_rd_data_i : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: the command latch is plain flops, so it is cleared on reset; a RAM
  // array would instead be left unreset since its contents are data, not state.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_owner   <= REQ_A;
    end else if (w_accept) begin
      if (w_grant[1]) begin
        r_wr_en   <= b_wr_en_i;
        r_rd_en   <= b_rd_en_i;
        r_addr    <= b_addr_i;
        r_wr_data <= b_wr_data_i;
        r_owner   <= REQ_B;
      end else begin
        r_wr_en   <= a_wr_en_i;
        r_rd_en   <= a_rd_en_i;
        r_addr    <= a_addr_i;
        r_wr_data <= a_wr_data_i;
        r_owner   <= REQ_A;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    a_ready_o   = 1'b0;
    b_ready_o   = 1'b0;
    mem_valid_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_rd_en_o = 1'b0;
    a_resp_o    = 1'b0;
    b_resp_o    = 1'b0;
    a_rd_data_o = '0;
    b_rd_data_o = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next    = ISSUE;
          a_ready_o = w_grant[0];
          b_ready_o = w_grant[1];
        end
      end
      ISSUE: begin
        w_next      = RESP;
        mem_valid_o = rst_i;
        mem_wr_en_o = rst_i && r_wr_en;
        mem_rd_en_o = rst_i && r_rd_en;
      end
      RESP: begin
        w_next = IDLE;
        if (r_owner == REQ_B) begin
          b_resp_o    = rst_i;
          b_rd_data_o = w_resp_data;
        end else begin
          a_resp_o    = rst_i;
          a_rd_data_o = w_resp_data;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The RAM raises ready one cycle after valid; we never stall on it.
  a_mem_ready_in_resp: assert property (
    @(posedge clk_i) disable iff (!rst_i) (r_state == RESP) |-> mem_ready_i
  );

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter with a behavioural 128x8 RAM that
// writes before it reads and raises ready the cycle after valid.
module tb_sp_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       a_valid, a_ready, a_wr, a_rd, a_resp;
  logic [6:0] a_addr;
  logic [7:0] a_wd, a_rdd;
  logic       b_valid, b_ready, b_wr, b_rd, b_resp;
  logic [6:0] b_addr;
  logic [7:0] b_wd, b_rdd;
  logic       mem_valid, mem_wr, mem_rd;
  logic       mem_ready = 1'b0;
  logic [6:0] mem_addr;
  logic [7:0] mem_wd;
  logic [7:0] mem_rdd = 8'h00;
  logic [7:0] ram [128];

  typedef struct {
    bit         owner;
    bit         wr;
    bit         rd;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         acc;
  } exp_t;

  exp_t sb[$];
  bit   own_log[$];
  int   cyc_log[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_push = 0;
  int   n_resp = 0;
  int   n_dropped = 0;
  int   a_cnt = 0;

  sp_ram_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .a_valid_i     (a_valid),
    .a_ready_o     (a_ready),
    .a_wr_en_i     (a_wr),
    .a_rd_en_i     (a_rd),
    .a_addr_i      (a_addr),
    .a_wr_data_i   (a_wd),
    .a_resp_o      (a_resp),
    .a_rd_data_o   (a_rdd),
    .b_valid_i     (b_valid),
    .b_ready_o     (b_ready),
    .b_wr_en_i     (b_wr),
    .b_rd_en_i     (b_rd),
    .b_addr_i      (b_addr),
    .b_wr_data_i   (b_wd),
    .b_resp_o      (b_resp),
    .b_rd_data_o   (b_rdd),
    .mem_valid_o   (mem_valid),
    .mem_ready_i   (mem_ready),
    .mem_wr_en_o   (mem_wr),
    .mem_rd_en_o   (mem_rd),
    .mem_addr_o    (mem_addr),
    .mem_wr_data_o (mem_wd),
    .mem_rd_data_i (mem_rdd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    mem_ready <= mem_valid;
    if (mem_valid) begin
      if (mem_wr) ram[mem_addr] <= mem_wd;
      if (mem_rd) mem_rdd <= mem_wr ? mem_wd : ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not expected or timed out (cycle %0d)", name, cyc);
  endtask

  task automatic drive(input bit who, input bit v, input bit wr, input bit rd,
                       input logic [6:0] addr, input logic [7:0] data);
    if (who) begin
      b_valid = v; b_wr = wr; b_rd = rd; b_addr = addr; b_wd = data;
    end else begin
      a_valid = v; a_wr = wr; a_rd = rd; a_addr = addr; a_wd = data;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input bit who, input bit wr, input bit rd, input logic [6:0] addr,
                      input logic [7:0] data, input logic [7:0] exp_rd);
    int   tries = 0;
    bit   got = 0;
    exp_t e;
    drive(who, 1'b1, wr, rd, addr, data);
    while (!got && tries < 60) begin
      #1;
      if (who ? b_ready : a_ready) got = 1;
      else begin
        @(negedge clk);
        tries++;
      end
    end
    if (got) begin
      e.owner = who; e.wr = wr; e.rd = rd; e.addr = addr;
      e.wdata = data; e.rdata = exp_rd; e.acc = cyc;
      sb.push_back(e);
      n_push++;
      own_log.push_back(who);
      cyc_log.push_back(cyc);
      @(negedge clk);
    end else begin
      fail(who ? "b_ready_timeout" : "a_ready_timeout");
    end
    drive(who, 1'b0, 1'b0, 1'b0, 7'd0, 8'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (a_resp && b_resp) fail("dual_resp");
      if (mem_valid) begin
        if (sb.size() == 0) fail("spurious_issue");
        else begin
          check("issue_cmd", {14'd0, mem_wr, mem_rd, mem_addr, mem_wd},
                {14'd0, sb[0].wr, sb[0].rd, sb[0].addr, sb[0].wdata});
          check("issue_latency", cyc, sb[0].acc + 1);
        end
      end
      if (a_resp || b_resp) begin
        if (sb.size() == 0) fail("spurious_resp");
        else begin
          e = sb.pop_front();
          n_resp++;
          check("resp_owner", {31'd0, b_resp}, {31'd0, e.owner});
          check("resp_data", e.owner ? b_rdd : a_rdd, e.rdata);
          check("loser_data", e.owner ? a_rdd : b_rdd, 0);
          check("resp_latency", cyc, e.acc + 2);
        end
      end
    end
  end

  initial begin
    int base;
    int guard;
    rst_i = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 7'd5, 8'h5A);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 7'd99, 8'h63);

    // Reset held with both requesters valid: nothing may be accepted.
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rst_ready", {30'd0, a_ready, b_ready}, 0);
      check("rst_strobes", {29'd0, mem_valid, a_resp, b_resp}, 0);
      check("rst_mem_bus", {17'd0, mem_addr, mem_wd}, 0);
    end
    rst_i = 1'b1;
    fork
      send(1'b0, 1'b1, 1'b0, 7'd5, 8'h5A, 8'h00);
      send(1'b1, 1'b1, 1'b0, 7'd99, 8'h63, 8'h00);
    join
    check("first_winner_a", {31'd0, own_log[0]}, 0);
    check("second_winner_b", {31'd0, own_log[1]}, 1);
    check("rst_gap", cyc_log[1] - cyc_log[0], 3);

    send(1'b0, 1'b0, 1'b1, 7'd5, 8'h00, 8'h5A);

    // Contention: last grant was A, so B leads and the two alternate.
    base = own_log.size();
    fork
      begin
        send(1'b0, 1'b1, 1'b0, 7'd10, 8'h11, 8'h00);
        send(1'b0, 1'b0, 1'b1, 7'd10, 8'h00, 8'h11);
      end
      begin
        send(1'b1, 1'b1, 1'b0, 7'd20, 8'h22, 8'h00);
        send(1'b1, 1'b0, 1'b1, 7'd20, 8'h00, 8'h22);
      end
    join
    for (int k = 0; k < 4; k++) begin
      check("rr_order", {31'd0, own_log[base + k]}, (k % 2 == 0) ? 1 : 0);
      if (k > 0) check("rr_gap", cyc_log[base + k] - cyc_log[base + k - 1], 3);
    end

    send(1'b1, 1'b1, 1'b1, 7'd33, 8'd33, 8'd33);
    send(1'b0, 1'b0, 1'b0, 7'd7, 8'h00, 8'h00);
    send(1'b0, 1'b0, 1'b1, 7'd99, 8'h00, 8'h63);

    // Reset lands in the RESP cycle of an A read: its response is dropped.
    send(1'b0, 1'b0, 1'b1, 7'd5, 8'h00, 8'h5A);
    @(negedge clk);
    rst_i = 1'b0;
    n_dropped += sb.size();
    sb.delete();
    #1;
    check("midrst_no_resp", {30'd0, a_resp, b_resp}, 0);
    @(negedge clk);
    #1;
    check("midrst_idle", {29'd0, mem_valid, a_resp, b_resp}, 0);
    check("midrst_latch_clear", {17'd0, mem_addr, mem_wd}, 0);
    @(negedge clk);
    rst_i = 1'b1;
    base = own_log.size();
    fork
      send(1'b0, 1'b0, 1'b1, 7'd33, 8'h00, 8'd33);
      send(1'b1, 1'b0, 1'b1, 7'd5, 8'h00, 8'h5A);
    join
    check("post_rst_winner_a", {31'd0, own_log[base]}, 0);
    check("post_rst_then_b", {31'd0, own_log[base + 1]}, 1);

    // Full sweep: A fills the RAM, B reads each word back once written.
    fork
      for (int i = 0; i < 128; i++) begin
        send(1'b0, 1'b1, 1'b0, 7'(i), 8'(2 * i), 8'h00);
        a_cnt = i + 1;
      end
      for (int j = 0; j < 128; j++) begin
        guard = 0;
        while (a_cnt <= j && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        if (a_cnt <= j) fail("sweep_wait_timeout");
        send(1'b1, 1'b0, 1'b1, 7'(j), 8'h00, 8'(2 * j));
      end
    join

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #3;
    check("sb_drained", sb.size(), 0);
    check("resp_count", n_resp, n_push - n_dropped);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
